// File: rtl/core0_uarc_pkg.sv
// Shared types for the core0 UARC receiver-bus sender.
package core0_uarc_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} uarc_src_state_t;

  // Width of the post-ack gap counter; GAP_CYCLES must fit in it.
  localparam int unsigned UARC_GAP_WIDTH = 8;

endpackage

// File: rtl/uarc_send_fifo.sv
// Word FIFO feeding the UARC sender: storage, wrap-bit pointers, occupancy, synchronous flush.
module uarc_send_fifo #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count_next,
  output logic [WORD_WIDTH-1:0] head_data_next
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   head_q, head_d, tail_q, tail_d;
  logic                  push_en, pop_en;

  assign count   = tail_q - head_q;
  assign full    = (count == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty   = (count == '0);
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & ~empty & ~flush;

  // Next pointer values; flush discards everything queued, including a same-cycle push.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = tail_q;
    end else begin
      if (push_en) tail_d = tail_q + 1'b1;
      if (pop_en)  head_d = head_q + 1'b1;
    end
  end

  assign count_next = tail_d - head_d;
  // Bypass the word being written when it becomes the new head (push into empty FIFO).
  assign head_data_next = (push_en && (head_d == tail_q)) ? push_data
                                                         : mem[head_d[ADDR_WIDTH-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_en) mem[tail_q[ADDR_WIDTH-1:0]] <= push_data;
  end

endmodule

// File: rtl/uarc_send_source.sv
// Presents queued host words to one core0 UARC receiver bus under the send/ack handshake.
module uarc_send_source
  import core0_uarc_pkg::*;
#(
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter int unsigned GAP_CYCLES      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_valid,
  input  logic [WORD_WIDTH-1:0]    host_data,
  output logic                     host_ready,
  input  logic                     flush,
  output logic                     send,
  output logic [WORD_WIDTH-1:0]    send_data,
  input  logic                     send_ack,
  output logic [FIFO_ADDR_WIDTH:0] count,
  output logic [WORD_WIDTH-1:0]    sent_total
);

  uarc_src_state_t             state_q, state_d;
  logic [UARC_GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [WORD_WIDTH-1:0]       send_data_q, send_data_d;
  logic [WORD_WIDTH-1:0]       sent_total_q;
  logic                        pop, full, empty;
  logic [FIFO_ADDR_WIDTH:0]    count_next;
  logic [WORD_WIDTH-1:0]       head_data_next;

  uarc_send_fifo #(
    .WORD_WIDTH(WORD_WIDTH),
    .ADDR_WIDTH(FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (host_valid),
    .push_data     (host_data),
    .pop           (pop),
    .flush         (flush),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .count_next    (count_next),
    .head_data_next(head_data_next)
  );

  assign host_ready = ~full;
  assign send       = (state_q == SEND);
  assign send_data  = send_data_q;
  assign sent_total = sent_total_q;

  // Handshake FSM next state, gap countdown and pop request.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_next != '0) state_d = SEND;
      end
      SEND: begin
        pop = send_ack;
        if (send_ack) begin
          if (GAP_CYCLES != 0) begin
            state_d = GAP;
            gap_d   = UARC_GAP_WIDTH'(GAP_CYCLES);
          end else if (count_next == '0) begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        // Last gap cycle: resume on the following edge.
        if (gap_q <= UARC_GAP_WIDTH'(1)) begin
          gap_d   = '0;
          state_d = (count_next != '0) ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      gap_d   = '0;
    end
  end

  // Track the head word; hold the last value once the FIFO drains so no stale slot leaks X.
  always_comb begin
    send_data_d = send_data_q;
    if (count_next != '0) send_data_d = head_data_next;
  end

  // State, gap counter, data and acknowledged-word registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      send_data_q  <= '0;
      sent_total_q <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      send_data_q <= send_data_d;
      // An ack in SEND counts even when a flush clears the queue in the same cycle.
      if (pop) sent_total_q <= sent_total_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_uarc_send_source.sv
// Directed bench: dut_a runs with no post-ack gap, dut_b with a 2-cycle gap.
module tb_uarc_send_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_flush, a_ack, a_ready, a_send;
  logic [31:0] a_data, a_send_data, a_total;
  logic [4:0]  a_count;
  logic        b_valid, b_flush, b_ack, b_ready, b_send;
  logic [31:0] b_data, b_send_data, b_total;
  logic [4:0]  b_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uarc_send_source #(
    .WORD_WIDTH(32), .FIFO_ADDR_WIDTH(4), .GAP_CYCLES(0)
  ) dut_a (
    .clk(clk), .reset(reset), .host_valid(a_valid), .host_data(a_data),
    .host_ready(a_ready), .flush(a_flush), .send(a_send), .send_data(a_send_data),
    .send_ack(a_ack), .count(a_count), .sent_total(a_total)
  );

  uarc_send_source #(
    .WORD_WIDTH(32), .FIFO_ADDR_WIDTH(4), .GAP_CYCLES(2)
  ) dut_b (
    .clk(clk), .reset(reset), .host_valid(b_valid), .host_data(b_data),
    .host_ready(b_ready), .flush(b_flush), .send(b_send), .send_data(b_send_data),
    .send_ack(b_ack), .count(b_count), .sent_total(b_total)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    {a_valid, a_flush, a_ack, b_valid, b_flush, b_ack} = '0;
    a_data = '0;
    b_data = '0;
    reset  = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk);
    tick();
    chk("rst_send",       32'(a_send), 32'd0);
    chk("rst_send_data",  a_send_data, 32'd0);
    chk("rst_count",      32'(a_count), 32'd0);
    chk("rst_sent_total", a_total, 32'd0);
    chk("rst_host_ready", 32'(a_ready), 32'd1);
    reset = 1'b1;
    tick();

    // Single word into empty FIFO, visible right after the push edge.
    a_valid = 1'b1; a_data = 32'h48;
    tick();
    a_valid = 1'b0;
    chk("single_send", 32'(a_send), 32'd1);
    chk("single_data", a_send_data, 32'h48);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_hold_data",  a_send_data, 32'h48);
      chk("single_hold_count", 32'(a_count), 32'd1);
      chk("single_hold_send",  32'(a_send), 32'd1);
    end
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("single_ack_send",  32'(a_send), 32'd0);
    chk("single_ack_total", a_total, 32'd1);
    chk("single_ack_count", 32'(a_count), 32'd0);

    // Fill to depth 16, then one ignored push.
    for (int i = 0; i < 16; i++) begin
      a_valid = 1'b1; a_data = 32'(i);
      tick();
    end
    chk("full_count", 32'(a_count), 32'd16);
    chk("full_ready", 32'(a_ready), 32'd0);
    a_data = 32'h10;
    tick();
    a_valid = 1'b0;
    chk("full_push_ignored", 32'(a_count), 32'd16);

    // Back-to-back drain: one word per cycle, send never drops.
    a_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_send", 32'(a_send), 32'd1);
      chk("b2b_data", a_send_data, 32'(i));
      tick();
    end
    a_ack = 1'b0;
    chk("b2b_end_send",  32'(a_send), 32'd0);
    chk("b2b_end_total", a_total, 32'd17);
    chk("b2b_end_count", 32'(a_count), 32'd0);

    // Stray ack while idle changes nothing.
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("stray_idle_count", 32'(a_count), 32'd0);
    chk("stray_idle_total", a_total, 32'd17);
    chk("stray_idle_send",  32'(a_send), 32'd0);
    a_valid = 1'b1; a_data = 32'h55;
    tick();
    a_valid = 1'b0;
    chk("stray_idle_next_data",  a_send_data, 32'h55);
    chk("stray_idle_next_count", 32'(a_count), 32'd1);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("post_stray_total", a_total, 32'd18);

    // Flush at count=5 with same-cycle ack and push.
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_data = 32'h20 + 32'(i);
      tick();
    end
    chk("pre_flush_count", 32'(a_count), 32'd5);
    chk("pre_flush_data",  a_send_data, 32'h20);
    a_valid = 1'b1; a_data = 32'h99; a_ack = 1'b1; a_flush = 1'b1;
    tick();
    {a_valid, a_ack, a_flush} = '0;
    chk("flush_total", a_total, 32'd19);
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_send",  32'(a_send), 32'd0);
    tick();
    chk("flush_stays_idle", 32'(a_send), 32'd0);
    a_valid = 1'b1; a_data = 32'h30;
    tick();
    a_valid = 1'b0;
    chk("post_flush_data",  a_send_data, 32'h30);
    chk("post_flush_count", 32'(a_count), 32'd1);

    // Gap of 2 cycles after each ack.
    b_valid = 1'b1; b_data = 32'h41;
    tick();
    b_data = 32'h42;
    tick();
    b_valid = 1'b0;
    chk("gap_first_send", 32'(b_send), 32'd1);
    chk("gap_first_data", b_send_data, 32'h41);
    chk("gap_count2",     32'(b_count), 32'd2);
    b_ack = 1'b1;
    tick();
    chk("gap_low1_send",  32'(b_send), 32'd0);
    chk("gap_low1_count", 32'(b_count), 32'd1);
    chk("gap_low1_total", b_total, 32'd1);
    // Ack stays high into the gap and must be ignored.
    tick();
    b_ack = 1'b0;
    chk("gap_low2_send",        32'(b_send), 32'd0);
    chk("gap_stray_ack_count",  32'(b_count), 32'd1);
    chk("gap_stray_ack_total",  b_total, 32'd1);
    tick();
    chk("gap_resume_send", 32'(b_send), 32'd1);
    chk("gap_resume_data", b_send_data, 32'h42);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    tick();
    tick();
    chk("gap_drain_send",  32'(b_send), 32'd0);
    chk("gap_drain_count", 32'(b_count), 32'd0);
    chk("gap_drain_total", b_total, 32'd2);

    // Reset mid-SEND drops send without a clock edge.
    b_valid = 1'b1; b_data = 32'h77;
    tick();
    b_valid = 1'b0;
    chk("midrst_pre_send", 32'(b_send), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_send",  32'(b_send), 32'd0);
    chk("midrst_count", 32'(b_count), 32'd0);
    chk("midrst_total", b_total, 32'd0);
    chk("midrst_data",  b_send_data, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_after_send", 32'(b_send), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uarc_send_source.md
Name: uarc_send_source

Overview:
- Hardware sender for one UARC receiver bus of core0; drives receiver_sends[i] / receiver_datas[i] and retires words on receiver_send_acks[i].
- Host-side logic (stdin bridge, DMA, another core's glue) pushes words into an internal FIFO. The block presents them to the core one at a time under the send/ack handshake.
- Sits beside core0_base in uforth-style system tops and benches, replacing the hand-driven receiver_sends regs.

Parameters:
WORD_WIDTH, 32, width of a UARC data word
FIFO_ADDR_WIDTH, 4, log2 of FIFO depth (DEPTH = 1 << FIFO_ADDR_WIDTH)
GAP_CYCLES, 0, idle cycles forced on send after each ack (0..255)

Ports:
clk  in  1  clock, all state changes on posedge
reset  in  1  asynchronous, active-low reset
host_valid  in  1  host offers host_data this cycle
host_data  in  WORD_WIDTH  word to enqueue
host_ready  out  1  FIFO can accept (count < DEPTH)
flush  in  1  synchronous discard of all queued words
send  out  1  to core receiver_sends[i]; word on send_data is valid
send_data  out  WORD_WIDTH  to core receiver_datas[i]
send_ack  in  1  from core receiver_send_acks[i]; current word consumed
count  out  FIFO_ADDR_WIDTH+1  words held, including the one being presented
sent_total  out  WORD_WIDTH  acknowledged-word counter, wraps modulo 2^WORD_WIDTH

Behaviour:
- Reset (reset low, async): send=0, send_data=0, count=0, sent_total=0, host_ready=1, head/tail pointers=0, state=IDLE. Release is synchronous to clk.
- Push: host_valid & host_ready sampled at posedge writes mem[tail], tail+1.
  - host_ready is combinational from count only. A push while full is ignored, even if an ack pops in the same cycle.
- Pointers carry an extra wrap bit. count = tail - head (mod 2^(FIFO_ADDR_WIDTH+1)). full = count==DEPTH; empty = count==0.
- send_data = mem[head], driven from a register updated whenever head or the head entry changes. It is stable for as long as send is high.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if next count != 0 and no flush, then state=SEND and send=1 after the same edge. Latency: word pushed at edge N into an empty FIFO is on send/send_data after edge N.
  - SEND: send=1. send_ack high at posedge retires mem[head]: head+1, sent_total+1.
    - GAP_CYCLES=0 and words remain: stay SEND, next word on send_data after that edge (back-to-back, send never drops).
    - GAP_CYCLES>0: go to GAP, send=0, load gap counter with GAP_CYCLES.
    - FIFO now empty and GAP_CYCLES=0: go to IDLE, send=0.
  - GAP: send=0. Counter decrements each cycle. At 0: go SEND if count != 0, else IDLE. Pushes are accepted during GAP.
- send_ack while send=0 (IDLE/GAP) is ignored: no pop, no count change.
- Simultaneous push and ack (not full): count unchanged, both take effect.
- flush: at the edge, head=tail and count=0. State goes to IDLE, send=0 after the edge. Gap counter is cleared.
  - flush has priority over a same-cycle push; the pushed word is discarded.
  - A same-cycle send_ack in SEND is still counted in sent_total before the clear.
- Reset asserted mid-SEND: send drops immediately (async); the queued word is lost.
- No X on outputs after reset; mem contents need not be reset.

Decomposition:
- Shared package core0_uarc_pkg holds:
  - typedef enum uarc_src_state_t {IDLE, SEND, GAP}
  - localparam UARC_GAP_WIDTH = 8
- Sub-module uarc_send_fifo: memory, pointers, count, full/empty, synchronous flush.
- uarc_send_source holds the FSM, gap counter, sent_total and the send_data register.

Test Plan:
- Reset: hold reset low 2 cycles -> send=0, send_data=0, count=0, sent_total=0, host_ready=1. Assert reset mid-SEND -> send=0 without waiting for clk.
- Single word, GAP_CYCLES=0: push 0x48 into empty FIFO.
  - send=1, send_data=0x48 after that edge.
  - No ack for 3 cycles -> data stable, count=1.
  - Ack 1 cycle -> send=0 next cycle, sent_total=1, count=0.
- Full/back-to-back, depth 16: push 0x00..0x0F without ack.
  - host_ready=0 at count=16; push of 0x10 ignored.
  - Hold send_ack high 16 cycles -> send_data steps 0x00..0x0F one per cycle, send continuously 1, then 0. sent_total=16.
- Gap, GAP_CYCLES=2: queue 0x41, 0x42; ack the first -> send low exactly 2 cycles, then high with 0x42.
- Flush with simultaneous ack and push at count=5 -> sent_total+1, count=0, send=0 next cycle, pushed word absent from later output.
- Stray ack: send_ack=1 while IDLE and during GAP -> count, head, sent_total unchanged.
